// File: rtl/jtcop_vidout.sv
// rtl/jtcop_vidout.sv - video output stage: sync realign, blanking, geometry measure, lock FSM
// Optional JTCOP_VIDOUT_PATTERN_EN adds pat_en and colour-bar replacement of visible RGB.
module jtcop_vidout #(
  parameter int SYNC_DLY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       HS,
  input  logic       VS,
  input  logic       LHBL_dly,
  input  logic       LVBL_dly,
  input  logic [7:0] red,
  input  logic [7:0] green,
  input  logic [7:0] blue,
`ifdef JTCOP_VIDOUT_PATTERN_EN
  input  logic       pat_en,
`endif
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       HS_o,
  output logic       VS_o,
  output logic       LHBL_o,
  output logic       LVBL_o,
  output logic       locked,
  input  logic [2:0] st_addr,
  output logic [7:0] st_dout
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [SYNC_DLY-1:0] r_hs_dly;
  logic [SYNC_DLY-1:0] r_vs_dly;
  logic [8:0]          r_hcnt;
  logic [8:0]          r_vcnt;
  logic [8:0]          r_hact;
  logic [8:0]          r_vact;
  logic [17:0]         r_ref;
  logic [7:0]          r_frame_cnt;

  logic                w_hfall;
  logic                w_vfall;
  logic                w_vis;
  logic                w_line;
  logic [8:0]          w_hact_nx;
  logic [8:0]          w_vcnt_inc;
  logic [8:0]          w_vact_nx;
  logic [17:0]         w_geo_nx;
  logic [7:0]          w_r_src;
  logic [7:0]          w_g_src;
  logic [7:0]          w_b_src;
  logic [7:0]          w_st;

  // LHBL_o/LVBL_o hold the previous pxl_cen sample, so they double as edge history
  assign w_hfall    = LHBL_o & ~LHBL_dly;
  assign w_vfall    = LVBL_o & ~LVBL_dly;
  assign w_vis      = LHBL_dly & LVBL_dly;
  // the line ending on the same tick as the frame still belongs to the frame
  assign w_line     = w_hfall & (LVBL_dly | w_vfall);
  assign w_hact_nx  = w_hfall ? r_hcnt : r_hact;
  assign w_vcnt_inc = (w_line && r_vcnt != 9'h1ff) ? r_vcnt + 9'd1 : r_vcnt;
  assign w_vact_nx  = w_vfall ? w_vcnt_inc : r_vact;
  assign w_geo_nx   = {w_hact_nx, w_vact_nx};

`ifdef JTCOP_VIDOUT_PATTERN_EN
  assign w_r_src = pat_en ? {8{r_hcnt[7]}} : red;
  assign w_g_src = pat_en ? {8{r_hcnt[6]}} : green;
  assign w_b_src = pat_en ? {8{r_hcnt[5]}} : blue;
`else
  assign w_r_src = red;
  assign w_g_src = green;
  assign w_b_src = blue;
`endif

  assign HS_o   = r_hs_dly[SYNC_DLY-1];
  assign VS_o   = r_vs_dly[SYNC_DLY-1];
  assign locked = (r_state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hs_dly <= '0;
      r_vs_dly <= '0;
    end else if (pxl_cen) begin
      r_hs_dly[0] <= HS;
      r_vs_dly[0] <= VS;
      for (int i = 1; i < SYNC_DLY; i++) begin
        r_hs_dly[i] <= r_hs_dly[i-1];
        r_vs_dly[i] <= r_vs_dly[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_o   <= 8'd0;
      green_o <= 8'd0;
      blue_o  <= 8'd0;
      LHBL_o  <= 1'b0;
      LVBL_o  <= 1'b0;
    end else if (pxl_cen) begin
      red_o   <= w_vis ? w_r_src : 8'd0;
      green_o <= w_vis ? w_g_src : 8'd0;
      blue_o  <= w_vis ? w_b_src : 8'd0;
      LHBL_o  <= LHBL_dly;
      LVBL_o  <= LVBL_dly;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hcnt      <= 9'd0;
      r_vcnt      <= 9'd0;
      r_hact      <= 9'd0;
      r_vact      <= 9'd0;
      r_ref       <= 18'd0;
      r_frame_cnt <= 8'd0;
    end else if (pxl_cen) begin
      r_hact <= w_hact_nx;
      r_vact <= w_vact_nx;
      if (w_hfall)
        r_hcnt <= 9'd0;
      else if (LHBL_dly && r_hcnt != 9'h1ff)
        r_hcnt <= r_hcnt + 9'd1;
      r_vcnt <= w_vfall ? 9'd0 : w_vcnt_inc;
      if (w_vfall) begin
        r_ref       <= w_geo_nx;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= UNLOCKED;
    else
      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    if (pxl_cen && w_vfall) begin
      case (r_state)
        UNLOCKED: w_state_nx = CHECK;
        CHECK:    w_state_nx = (w_geo_nx == r_ref) ? LOCKED : CHECK;
        LOCKED:   w_state_nx = (w_geo_nx == r_ref) ? LOCKED : CHECK;
        default:  w_state_nx = UNLOCKED;
      endcase
    end
  end

  always_comb begin
    w_st = 8'hff;
    case (st_addr)
      3'd0:    w_st = r_hact[7:0];
      3'd1:    w_st = {7'd0, r_hact[8]};
      3'd2:    w_st = r_vact[7:0];
      3'd3:    w_st = {7'd0, r_vact[8]};
      3'd4:    w_st = r_frame_cnt;
      3'd5:    w_st = {6'd0, r_state};
      default: w_st = 8'hff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      st_dout <= 8'd0;
    else
      st_dout <= w_st;
  end

endmodule

// File: tb/tb_jtcop_vidout.sv
// tb/tb_jtcop_vidout.sv - directed self-checking bench for jtcop_vidout
module tb_jtcop_vidout;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       HS = 1'b0, VS = 1'b0;
  logic       LHBL_dly = 1'b0, LVBL_dly = 1'b0;
  logic [7:0] red = 8'd0, green = 8'd0, blue = 8'd0;
`ifdef JTCOP_VIDOUT_PATTERN_EN
  logic       pat_en = 1'b0;
`endif
  logic [7:0] red_o, green_o, blue_o;
  logic       HS_o, VS_o, LHBL_o, LVBL_o, locked;
  logic [2:0] st_addr = 3'd0;
  logic [7:0] st_dout;

  int total = 0;
  int bad   = 0;

  jtcop_vidout #(.SYNC_DLY(3)) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen),
    .HS(HS), .VS(VS), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly),
    .red(red), .green(green), .blue(blue),
`ifdef JTCOP_VIDOUT_PATTERN_EN
    .pat_en(pat_en),
`endif
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .HS_o(HS_o), .VS_o(VS_o), .LHBL_o(LHBL_o), .LVBL_o(LVBL_o),
    .locked(locked), .st_addr(st_addr), .st_dout(st_dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one pixel tick: a pxl_cen clock followed by an idle clock
  task automatic step();
    pxl_cen = 1'b1;
    @(posedge clk); #1;
    pxl_cen = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic chk_st(input string tag, input logic [2:0] a, input logic [7:0] exp);
    st_addr = a;
    @(posedge clk); #1;
    chk(tag, {8'd0, st_dout}, {8'd0, exp});
  endtask

  task automatic line(input int w, input logic lv);
    LVBL_dly = lv;
    LHBL_dly = 1'b1;
    repeat (w) step();
    LHBL_dly = 1'b0;
    repeat (2) step();
  endtask

  // vblank line, 239 short lines, a last line of lastw pixels, then the frame end
  task automatic frame(input int lastw);
    line(4, 1'b0);
    for (int i = 0; i < 239; i++) line(4, 1'b1);
    line(lastw, 1'b1);
    LVBL_dly = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_red_o", {8'd0, red_o}, 16'h0);
    chk("rst_hs_o", {15'd0, HS_o}, 16'h0);
    chk("rst_lhbl_o", {15'd0, LHBL_o}, 16'h0);
    chk("rst_locked", {15'd0, locked}, 16'h0);
    chk("rst_st_dout", {8'd0, st_dout}, 16'h0);
    chk_st("rst_state", 3'd5, 8'h00);
    chk_st("st6_ff", 3'd6, 8'hff);
    chk_st("st7_ff", 3'd7, 8'hff);

    // sync delay and blanking
    repeat (2) step();
    HS = 1'b1; VS = 1'b1;
    step(); chk("hs_tick1", {15'd0, HS_o}, 16'h0);
    step(); chk("hs_tick2", {15'd0, HS_o}, 16'h0);
    step(); chk("hs_tick3", {15'd0, HS_o}, 16'h1);
    chk("vs_tick3", {15'd0, VS_o}, 16'h1);
    HS = 1'b0; VS = 1'b0;
    LHBL_dly = 1'b0; LVBL_dly = 1'b1; red = 8'h55;
    step();
    chk("blank_red", {8'd0, red_o}, 16'h0);
    LHBL_dly = 1'b1;
    @(posedge clk); #1;
    chk("hold_red", {8'd0, red_o}, 16'h0);
    step();
    chk("vis_red", {8'd0, red_o}, 16'h55);
    chk("vis_lhbl_o", {15'd0, LHBL_o}, 16'h1);
    red = 8'h00; LHBL_dly = 1'b0; LVBL_dly = 1'b0;

    // 320x240 lock-in over three frames
    do_reset();
    frame(320);
    chk_st("f1_state", 3'd5, 8'h01);
    chk("f1_locked", {15'd0, locked}, 16'h0);
    frame(320);
    chk("f2_locked", {15'd0, locked}, 16'h1);
    frame(320);
    chk_st("f3_hact_lo", 3'd0, 8'h40);
    chk_st("f3_hact_hi", 3'd1, 8'h01);
    chk_st("f3_vact_lo", 3'd2, 8'hf0);
    chk_st("f3_vact_hi", 3'd3, 8'h00);
    chk_st("f3_frames", 3'd4, 8'h03);
    chk_st("f3_state", 3'd5, 8'h02);

    // geometry glitch drops lock, two good frames regain it
    frame(256);
    chk("g_locked", {15'd0, locked}, 16'h0);
    chk_st("g_state", 3'd5, 8'h01);
    chk_st("g_hact_lo", 3'd0, 8'h00);
    chk_st("g_hact_hi", 3'd1, 8'h01);
    frame(320);
    chk("g2_locked", {15'd0, locked}, 16'h0);
    frame(320);
    chk("g3_locked", {15'd0, locked}, 16'h1);

    // reset mid-line
    red = 8'h55; HS = 1'b1; LVBL_dly = 1'b1; LHBL_dly = 1'b1;
    repeat (10) step();
    chk("pre_rst_red", {8'd0, red_o}, 16'h55);
    rst = 1'b1; st_addr = 3'd4;
    @(posedge clk); #1;
    chk("mid_rst_red", {8'd0, red_o}, 16'h0);
    chk("mid_rst_hs", {15'd0, HS_o}, 16'h0);
    chk("mid_rst_lhbl", {15'd0, LHBL_o}, 16'h0);
    chk("mid_rst_locked", {15'd0, locked}, 16'h0);
    chk("mid_rst_st", {8'd0, st_dout}, 16'h0);
    rst = 1'b0; HS = 1'b0; red = 8'h00;
    chk_st("mid_rst_hact", 3'd0, 8'h00);
    chk_st("mid_rst_frames", 3'd4, 8'h00);
    frame(320);
    chk_st("mid_rst_f1_state", 3'd5, 8'h01);
    chk("mid_rst_f1_locked", {15'd0, locked}, 16'h0);

    // hcnt saturation and frame counter wrap
    do_reset();
    LVBL_dly = 1'b1; LHBL_dly = 1'b1;
    repeat (600) step();
    LHBL_dly = 1'b0;
    step();
    chk_st("sat_hact_lo", 3'd0, 8'hff);
    chk_st("sat_hact_hi", 3'd1, 8'h01);
    LVBL_dly = 1'b0;
    step();
    chk_st("sat_vact_lo", 3'd2, 8'h01);
    chk_st("wrap_fc1", 3'd4, 8'h01);
    for (int i = 0; i < 254; i++) begin
      LVBL_dly = 1'b1; step();
      LVBL_dly = 1'b0; step();
    end
    chk_st("wrap_fc255", 3'd4, 8'hff);
    LVBL_dly = 1'b1; step();
    LVBL_dly = 1'b0; step();
    chk_st("wrap_fc0", 3'd4, 8'h00);
    chk_st("wrap_state", 3'd5, 8'h02);

`ifdef JTCOP_VIDOUT_PATTERN_EN
    // colour bars at hcnt=160
    do_reset();
    pat_en = 1'b1; red = 8'h12; green = 8'h34; blue = 8'h56;
    LVBL_dly = 1'b1; LHBL_dly = 1'b1;
    repeat (161) step();
    chk("pat_red", {8'd0, red_o}, 16'hff);
    chk("pat_green", {8'd0, green_o}, 16'h00);
    chk("pat_blue", {8'd0, blue_o}, 16'hff);
    LHBL_dly = 1'b0;
    step();
    chk("pat_blank_red", {8'd0, red_o}, 16'h00);
    chk("pat_blank_blue", {8'd0, blue_o}, 16'h00);
    pat_en = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
